tx_cw_shaper: RTL and testbench
===============================

Name: tx_cw_shaper

Overview:
Parametrised CW envelope generator and TX sample-source selector, placed between the CIC interpolator output and the TX CORDIC.
- Replaces the fixed 512-step up/down profile counter, which ran on a separately synchronised slow clock, with a four-state ramp FSM on the main clock and a runtime step prescaler.
- Reads an external synchronous profile ROM, scales it by a runtime CW level, and outputs either the envelope (I = env, Q = 0) or the interpolated I/Q stream, with both paths latency-matched.

Parameters:
PAW, 9, profile ROM address width; ramp has MAX = 2^PAW-1 steps.
SW, 16, signed I/Q sample width (1 <= SW-1 <= 32).
PRE_W, 16, prescaler width.

Ports:
clock  in  1  system clock (DAC rate).
reset  in  1  asynchronous active-low reset.
cw  in  1  key input, already synchronised to clock; 1 = key down.
step_div  in  PRE_W  ramp step period minus one, in clocks.
cw_level  in  16  unsigned CW amplitude, 65535 = full scale.
in_i  in  SW  signed I sample, one per clock.
in_q  in  SW  signed Q sample, one per clock.
prof_addr  out  PAW  profile ROM address (registered).
prof_data  in  16  unsigned profile ROM data, valid 1 clock after prof_addr.
out_i  out  SW  signed I to CORDIC.
out_q  out  SW  signed Q to CORDIC.
cw_active  out  1  1 while out_i/out_q carry the CW envelope.
state  out  2  FSM state: 0 IDLE, 1 RAMP_UP, 2 HOLD, 3 RAMP_DOWN.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, prof_addr=0, prescaler=0, all pipeline registers=0.
  - out_i=out_q=0, cw_active=0.
  - Applies mid-ramp with no completion of the ramp.
- Prescaler:
  - Held at 0 in IDLE and HOLD.
  - Otherwise counts up; tick=1 when count>=step_div, and the count reloads to 0 on that cycle.
  - A step_div change takes effect on the next compare.
  - step_div=0 gives a tick every clock.
- FSM, evaluated every clock, first matching rule wins:
  - IDLE: cw=1 -> RAMP_UP.
  - RAMP_UP: cw=0 -> RAMP_DOWN, addr held. Else addr==MAX -> HOLD. Else on tick addr+1.
  - HOLD: cw=0 -> RAMP_DOWN. addr stays MAX.
  - RAMP_DOWN: cw=1 -> RAMP_UP, addr held, so no envelope discontinuity. Else addr==0 -> IDLE. Else on tick addr-1.
- Direction reversal mid-ramp resumes from the current addr. A key-down shorter than one tick produces RAMP_UP -> RAMP_DOWN -> IDLE with addr=0 throughout.
- addr never wraps; it is bounded to 0..MAX.
- Envelope: prod = prof_data*cw_level, 32-bit unsigned; env = prod[31 -: SW-1], zero-extended to SW bits, so env is always non-negative.
- Pipeline (sel = state!=IDLE):
  - Stage 1: ROM output registered externally; sel_d1, in_i_d1 and in_q_d1 registered here.
  - Stage 2 (registered): out_i = sel_d1 ? env : in_i_d1; out_q = sel_d1 ? 0 : in_q_d1; cw_active = sel_d1.
- Latency: 2 clocks from prof_addr/state change to output, and 2 clocks from in_i/in_q to output.
- The switch from I/Q to CW occurs while prof_addr=0, so the first CW sample is env(prof_data[0]).
- Ramp timing: full ramp-up from IDLE takes MAX*(step_div+1) clocks of RAMP_UP, plus 1 clock to enter HOLD.
- cw_level is applied to the next product with no hold-off; changes during HOLD take effect 1 clock later at the output.

Test Plan:
1. Reset release, cw=0, in_i=1234, in_q=-5 -> out_i=1234, out_q=-5 two clocks later; state=0; cw_active=0.
2. PAW=3, step_div=0, ROM = addr*8192, cw_level=65535, cw held 1 from cycle 0:
   - state=1 after edge 0; prof_addr reaches 7 at edge 7; state=2 at edge 8.
   - out_i sequence 0, 4095, 8191, ... 28671 with out_q=0; cw_active=1 from edge 2.
3. From HOLD with cw=0 and step_div=3:
   - prof_addr decrements once every 4 clocks, 7 -> 0.
   - IDLE is entered one clock after addr=0; out returns to in_i/in_q and cw_active=0 two clocks later.
4. cw drops at addr=4 during RAMP_UP, then rises at addr=2 during RAMP_DOWN:
   - addr sequence 4,4,3,2,2,3... with no jump; state 1->3->1.
5. cw pulse of 2 clocks with step_div=10 -> states 1,3,0; prof_addr stays 0; cw_active high for 3 clocks; out_i = env(prof_data[0]).
6. Async reset asserted mid-ramp at addr=5 (reset=0 between clock edges):
   - prof_addr, out_i and cw_active go to 0 immediately without a clock edge.
   - After release with cw=1 the ramp restarts from addr 0.

Source files
------------

// File: rtl/tx_cw_shaper.sv
// tx_cw_shaper
//   CW envelope generator and TX sample-source selector. Sits between the
//   CIC interpolator output and the TX CORDIC. A four-state ramp FSM walks
//   an external synchronous profile ROM up and down. A runtime prescaler
//   sets the time per ramp step. The ROM word is scaled by a runtime CW
//   level. The module outputs either that envelope (I = env, Q = 0) or the
//   interpolated I/Q stream. Both paths have the same latency.
//
// Ports
//   clock      system clock (DAC rate)
//   reset      asynchronous active-low reset
//   cw         key input, already synchronous to clock, 1 = key down
//   step_div   ramp step period minus one, in clocks
//   cw_level   unsigned CW amplitude, 65535 = full scale
//   in_i/in_q  signed interpolated I/Q samples, one per clock
//   prof_addr  profile ROM address (registered)
//   prof_data  profile ROM data, valid one clock after prof_addr
//   out_i/out_q signed samples to the CORDIC
//   cw_active  1 while out_i/out_q carry the CW envelope
//   state      0 IDLE, 1 RAMP_UP, 2 HOLD, 3 RAMP_DOWN
module tx_cw_shaper #(
   parameter int PAW   = 9,
   parameter int SW    = 16,
   parameter int PRE_W = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cw,
   input  logic [PRE_W-1:0]     step_div,
   input  logic [15:0]          cw_level,
   input  logic signed [SW-1:0] in_i,
   input  logic signed [SW-1:0] in_q,
   output logic [PAW-1:0]       prof_addr,
   input  logic [15:0]          prof_data,
   output logic signed [SW-1:0] out_i,
   output logic signed [SW-1:0] out_q,
   output logic                 cw_active,
   output logic [1:0]           state
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      HOLD      = 2'd2,
      RAMP_DOWN = 2'd3
   } state_t;

   localparam logic [PAW-1:0] ADDR_MAX = {PAW{1'b1}};

   state_t              state_reg, state_next;
   logic [PAW-1:0]      addr_reg, addr_next;
   logic [PRE_W-1:0]    pre_reg, pre_next;
   logic                tick;

   logic                sel_d1_reg;
   logic signed [SW-1:0] in_i_d1_reg, in_q_d1_reg;
   logic [SW-1:0]       env;

   // The prescaler runs only while ramping. The compare is against the
   // live step_div, so a new divider applies at the very next compare.
   always_comb begin : prescaler
      tick     = 1'b0;
      pre_next = '0;
      if ((state_reg == RAMP_UP) || (state_reg == RAMP_DOWN)) begin
         if (pre_reg >= step_div)
            tick = 1'b1;
         else
            pre_next = pre_reg + PRE_W'(1);
      end
   end

   // On a key reversal the address is held for that clock. The envelope
   // therefore retraces from where it is, with no jump.
   always_comb begin : fsm_next
      state_next = state_reg;
      addr_next  = addr_reg;
      case (state_reg)
         IDLE: begin
            if (cw)
               state_next = RAMP_UP;
         end
         RAMP_UP: begin
            if (!cw)
               state_next = RAMP_DOWN;
            else if (addr_reg == ADDR_MAX)
               state_next = HOLD;
            else if (tick)
               addr_next = addr_reg + PAW'(1);
         end
         HOLD: begin
            if (!cw)
               state_next = RAMP_DOWN;
         end
         RAMP_DOWN: begin
            if (cw)
               state_next = RAMP_UP;
            else if (addr_reg == '0)
               state_next = IDLE;
            else if (tick)
               addr_next = addr_reg - PAW'(1);
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         pre_reg   <= '0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         pre_reg   <= pre_next;
      end
   end

   assign prof_addr = addr_reg;
   assign state     = state_reg;

   // env is the top SW-1 bits of the 32-bit unsigned product, with a
   // leading zero. The CW envelope therefore never reads as negative.
   assign env = SW'(({16'd0, prof_data} * {16'd0, cw_level}) >> (33 - SW));

   // Stage 1 delays the select and the I/Q stream by one clock, the same
   // delay the external ROM adds to the address. Stage 2 picks the source.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sel_d1_reg  <= 1'b0;
         in_i_d1_reg <= '0;
         in_q_d1_reg <= '0;
         out_i       <= '0;
         out_q       <= '0;
         cw_active   <= 1'b0;
      end else begin
         sel_d1_reg  <= (state_reg != IDLE);
         in_i_d1_reg <= in_i;
         in_q_d1_reg <= in_q;
         out_i       <= sel_d1_reg ? env : in_i_d1_reg;
         out_q       <= sel_d1_reg ? '0 : in_q_d1_reg;
         cw_active   <= sel_d1_reg;
      end
   end

endmodule

// File: tb/tb_tx_cw_shaper.sv
// tb_tx_cw_shaper
//   Self-checking bench for tx_cw_shaper with PAW=3 (MAX=7). It uses a
//   synchronous profile ROM and a behavioural reference model. The model
//   walks a ramp position and keeps a two-cycle history of what the
//   outputs should carry.
module tb_tx_cw_shaper;

   localparam int PAW   = 3;
   localparam int SW    = 16;
   localparam int PRE_W = 16;
   localparam int MAX   = (1 << PAW) - 1;
   localparam int VW    = 2 + PAW + 2 * SW + 1;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic                 cw = 1'b0;
   logic [PRE_W-1:0]     step_div = '0;
   logic [15:0]          cw_level = '0;
   logic signed [SW-1:0] in_i = '0;
   logic signed [SW-1:0] in_q = '0;
   logic [PAW-1:0]       prof_addr;
   logic [15:0]          prof_data;
   logic signed [SW-1:0] out_i;
   logic signed [SW-1:0] out_q;
   logic                 cw_active;
   logic [1:0]           state;

   logic [15:0] rom [0:MAX];

   int n_cmp  = 0;
   int n_fail = 0;

   tx_cw_shaper #(.PAW(PAW), .SW(SW), .PRE_W(PRE_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .cw        (cw),
      .step_div  (step_div),
      .cw_level  (cw_level),
      .in_i      (in_i),
      .in_q      (in_q),
      .prof_addr (prof_addr),
      .prof_data (prof_data),
      .out_i     (out_i),
      .out_q     (out_q),
      .cw_active (cw_active),
      .state     (state)
   );

   always #5 clock = ~clock;

   always @(posedge clock) prof_data <= rom[prof_addr];

   // ---------------- reference model ----------------
   int          m_state, m_addr, m_cnt;
   logic        h1_sel, h2_sel;
   int unsigned h1_data, h2_data, h1_lvl;
   logic [SW-1:0] h1_i, h1_q, h2_i, h2_q;
   logic [1:0]    exp_state;
   logic [PAW-1:0] exp_addr;
   logic [SW-1:0] exp_i, exp_q;
   logic          exp_act;

   function automatic logic [SW-1:0] env_of(input longint unsigned data,
                                            input longint unsigned lvl);
      return SW'((data * lvl) / (64'd1 << (33 - SW)));
   endfunction

   function automatic logic [VW-1:0] obs_vec();
      return {state, prof_addr, out_i, out_q, cw_active};
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      return {exp_state, exp_addr, exp_i, exp_q, exp_act};
   endfunction

   task automatic model_reset();
      m_state = 0; m_addr = 0; m_cnt = 0;
      h1_sel = 0; h2_sel = 0; h1_data = 0; h2_data = 0; h1_lvl = 0;
      h1_i = '0; h1_q = '0; h2_i = '0; h2_q = '0;
      exp_state = '0; exp_addr = '0; exp_i = '0; exp_q = '0; exp_act = 0;
   endtask

   // Ramp position: moves one step every (step_div+1) ramping clocks,
   // clamped to 0..MAX, turning around on key changes.
   task automatic advance_ramp();
      bit ramping, step;
      ramping = (m_state == 1) || (m_state == 3);
      step    = ramping && (m_cnt >= int'(step_div));
      m_cnt   = (ramping && !step) ? m_cnt + 1 : 0;
      case (m_state)
         0: if (cw) m_state = 1;
         1: if (!cw) m_state = 3;
            else if (m_addr == MAX) m_state = 2;
            else if (step) m_addr = m_addr + 1;
         2: if (!cw) m_state = 3;
         default: if (cw) m_state = 1;
            else if (m_addr == 0) m_state = 0;
            else if (step) m_addr = m_addr - 1;
      endcase
   endtask

   // One rising edge; afterwards exp_* hold what the DUT should show.
   task automatic clk_step();
      logic c_sel; int unsigned c_data, c_lvl; logic [SW-1:0] c_i, c_q;
      @(posedge clock);
      if (!reset) begin
         model_reset();
      end else begin
         c_sel = (m_state != 0); c_data = rom[m_addr];
         c_i = in_i; c_q = in_q; c_lvl = cw_level;
         advance_ramp();
         h2_sel = h1_sel; h2_data = h1_data; h2_i = h1_i; h2_q = h1_q;
         h1_sel = c_sel;  h1_data = c_data;  h1_i = c_i;  h1_q = c_q;
         h1_lvl = c_lvl;
         exp_state = 2'(m_state);
         exp_addr  = PAW'(m_addr);
         exp_act   = h2_sel;
         exp_i     = h2_sel ? env_of(h2_data, h1_lvl) : h2_i;
         exp_q     = h2_sel ? '0 : h2_q;
      end
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1 reset = 1'b0;
      #1;
      n_cmp++;
      if (obs_vec() !== '0) begin
         n_fail++;
         $display("FAIL reset_async got %h want 0", obs_vec());
      end
      model_reset();
      for (int k = 0; k < 2; k++) begin
         clk_step();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_held k=%0d got %h want %h", k, obs_vec(), exp_vec());
         end
      end
      @(negedge clock) reset = 1'b1;
   endtask

   task automatic test_passthrough();
      cw = 0; in_i = 16'sd1234; in_q = -16'sd5;
      clk_step(); clk_step();
      n_cmp++;
      if (out_i !== 16'sd1234 || out_q !== -16'sd5 || state !== 2'd0 || cw_active !== 1'b0) begin
         n_fail++;
         $display("FAIL passthrough got i=%0d q=%0d st=%0d act=%0d want 1234 -5 0 0",
                  out_i, out_q, state, cw_active);
      end
      for (int k = 0; k < 20; k++) begin
         in_i = SW'($urandom); in_q = SW'($urandom);
         clk_step();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL passthrough_rand k=%0d got %h want %h", k, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_ramp_up();
      int want;
      for (int a = 0; a <= MAX; a++) rom[a] = 16'(a * 8192);
      cw_level = 16'hFFFF; step_div = '0; cw = 1;
      for (int k = 0; k < 12; k++) begin
         clk_step();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL ramp_up k=%0d got %h want %h", k, obs_vec(), exp_vec());
         end
         if (k == 0 || k == 7 || k == 8) begin
            n_cmp++;
            if (state !== ((k == 8) ? 2'd2 : 2'd1) || prof_addr !== PAW'((k == 0) ? 0 : 7)) begin
               n_fail++;
               $display("FAIL ramp_up_edge k=%0d got st=%0d a=%0d", k, state, prof_addr);
            end
         end
         if (k >= 2) begin
            want = (((k - 2 > 7) ? 7 : k - 2) * 8192 * 64'd65535) >> 17;
            n_cmp++;
            if (out_i !== SW'(want) || out_q !== '0 || cw_active !== 1'b1) begin
               n_fail++;
               $display("FAIL ramp_up_env k=%0d got i=%0d q=%0d act=%0d want %0d 0 1",
                        k, out_i, out_q, cw_active, want);
            end
         end
      end
   endtask

   task automatic test_ramp_down();
      int last_edge, prev_addr, idle_at;
      step_div = 16'd3; cw = 0;
      last_edge = -1; prev_addr = int'(prof_addr); idle_at = -1;
      for (int n = 0; n < 60 && (idle_at < 0 || n <= idle_at + 2); n++) begin
         clk_step();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL ramp_down n=%0d got %h want %h", n, obs_vec(), exp_vec());
         end
         if (n == 0) last_edge = 0;
         if (int'(prof_addr) != prev_addr) begin
            n_cmp++;
            if (n - last_edge != 4 || int'(prof_addr) != prev_addr - 1) begin
               n_fail++;
               $display("FAIL ramp_down_step n=%0d got addr=%0d gap=%0d want addr=%0d gap=4",
                        n, prof_addr, n - last_edge, prev_addr - 1);
            end
            last_edge = n; prev_addr = int'(prof_addr);
         end
         if (idle_at < 0 && state == 2'd0) idle_at = n;
         if (idle_at >= 0 && n == idle_at + 1 || idle_at >= 0 && n == idle_at + 2) begin
            n_cmp++;
            if (cw_active !== (n == idle_at + 1)) begin
               n_fail++;
               $display("FAIL ramp_down_exit n=%0d got act=%0d want %0d",
                        n, cw_active, n == idle_at + 1);
            end
         end
      end
      n_cmp++;
      if (idle_at < 0 || prev_addr != 0) begin
         n_fail++;
         $display("FAIL ramp_down_done got idle_at=%0d addr=%0d want idle and 0", idle_at, prev_addr);
      end
   endtask

   task automatic test_reversal();
      int want_a [6] = '{4, 3, 2, 2, 3, 4};
      int want_s [6] = '{3, 3, 3, 1, 1, 1};
      bit reached;
      step_div = '0; cw = 1; reached = 0;
      for (int n = 0; n < 40 && !reached; n++) begin
         clk_step();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reversal_up n=%0d got %h want %h", n, obs_vec(), exp_vec());
         end
         if (state == 2'd1 && prof_addr == PAW'(4)) reached = 1;
      end
      cw = 0;
      for (int n = 0; n < 6; n++) begin
         clk_step();
         if (n == 2) cw = 1;
         n_cmp++;
         if (!reached || obs_vec() !== exp_vec() || int'(prof_addr) != want_a[n] || int'(state) != want_s[n]) begin
            n_fail++;
            $display("FAIL reversal n=%0d got %h a=%0d st=%0d want %h a=%0d st=%0d",
                     n, obs_vec(), prof_addr, state, exp_vec(), want_a[n], want_s[n]);
         end
      end
      cw = 0;
      for (int n = 0; n < 80 && m_state != 0; n++) clk_step();
      clk_step(); clk_step();
   endtask

   task automatic test_short_pulse();
      int want_s [8] = '{1, 1, 3, 0, 0, 0, 0, 0};
      int act_cnt;
      logic [SW-1:0] want_env;
      for (int a = 0; a <= MAX; a++) rom[a] = 16'($urandom);
      cw_level = 16'($urandom); step_div = 16'd10; cw = 1; act_cnt = 0;
      want_env = env_of(rom[0], cw_level);
      for (int n = 0; n < 8; n++) begin
         clk_step();
         if (n == 1) cw = 0;
         if (cw_active) act_cnt++;
         n_cmp++;
         if (obs_vec() !== exp_vec() || prof_addr !== '0 || int'(state) != want_s[n] ||
             (cw_active && out_i !== want_env)) begin
            n_fail++;
            $display("FAIL short_pulse n=%0d got %h want %h st_want=%0d env_want=%0d",
                     n, obs_vec(), exp_vec(), want_s[n], want_env);
         end
      end
      n_cmp++;
      if (act_cnt != 3) begin
         n_fail++;
         $display("FAIL short_pulse_active got %0d clocks want 3", act_cnt);
      end
   endtask

   task automatic test_async_reset();
      bit reached;
      for (int a = 0; a <= MAX; a++) rom[a] = 16'(a * 8192);
      cw_level = 16'hFFFF; step_div = 16'd1; cw = 1; reached = 0;
      for (int n = 0; n < 40 && !reached; n++) begin
         clk_step();
         if (m_addr == 5) reached = 1;
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if (!reached || prof_addr !== '0 || out_i !== '0 || cw_active !== 1'b0 || state !== 2'd0) begin
         n_fail++;
         $display("FAIL async_reset reached=%0d got a=%0d i=%0d act=%0d st=%0d want 0 0 0 0",
                  reached, prof_addr, out_i, cw_active, state);
      end
      clk_step();
      @(negedge clock) reset = 1'b1;
      clk_step();
      n_cmp++;
      if (state !== 2'd1 || prof_addr !== '0) begin
         n_fail++;
         $display("FAIL async_restart got st=%0d a=%0d want 1 0", state, prof_addr);
      end
      for (int n = 0; n < 20; n++) begin
         clk_step();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_after n=%0d got %h want %h", n, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      int hold;
      for (int a = 0; a <= MAX; a++) rom[a] = 16'($urandom);
      hold = 0;
      for (int n = 0; n < 1500; n++) begin
         in_i = SW'($urandom); in_q = SW'($urandom);
         if (hold == 0) begin
            cw = ~cw; hold = $urandom_range(1, 40);
         end
         hold--;
         if ($urandom_range(0, 31) == 0) step_div = PRE_W'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) cw_level = 16'($urandom);
         clk_step();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random n=%0d got %h want %h", n, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      for (int a = 0; a <= MAX; a++) rom[a] = '0;
      model_reset();
      test_reset();
      test_passthrough();
      test_ramp_up();
      test_ramp_down();
      test_reversal();
      test_short_pulse();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
